// File: rtl/alu_pkg.sv
// Op codes and mul/div FSM encodings for the execute-stage ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADDU  = 5'h00;
    localparam logic [4:0] OP_SUBU  = 5'h01;
    localparam logic [4:0] OP_SLT   = 5'h02;
    localparam logic [4:0] OP_AND   = 5'h03;
    localparam logic [4:0] OP_NOR   = 5'h04;
    localparam logic [4:0] OP_OR    = 5'h05;
    localparam logic [4:0] OP_XOR   = 5'h06;
    localparam logic [4:0] OP_SLL   = 5'h07;
    localparam logic [4:0] OP_SRL   = 5'h08;
    localparam logic [4:0] OP_SLTU  = 5'h09;
    localparam logic [4:0] OP_SRA   = 5'h0A;
    localparam logic [4:0] OP_LUI   = 5'h0B;
    localparam logic [4:0] OP_MULT  = 5'h0C;
    localparam logic [4:0] OP_MULTU = 5'h0D;
    localparam logic [4:0] OP_DIV   = 5'h0E;
    localparam logic [4:0] OP_DIVU  = 5'h0F;
    localparam logic [4:0] OP_MFHI  = 5'h10;
    localparam logic [4:0] OP_MFLO  = 5'h11;
    localparam logic [4:0] OP_MTHI  = 5'h12;
    localparam logic [4:0] OP_MTLO  = 5'h13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle; done_o high for the
// single DONE cycle with final hi/lo. ALU_MUL_EARLY_TERM_EN ends MUL once the multiplier is exhausted.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dz_o
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_e        state_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 is_div_q;
    logic                 neg_lo_q;
    logic                 neg_hi_q;
    logic                 dz_q;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       r_sh;
    logic [WIDTH:0]       r_diff;
    logic                 last_cnt;
    logic                 mul_last;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;

    always_comb begin
        mag_a    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        mag_b    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
        // Divider holds remainder in acc upper half, shifting dividend/quotient in lower half.
        r_sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        r_diff   = r_sh - {1'b0, mcand_q[WIDTH-1:0]};
        last_cnt = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef ALU_MUL_EARLY_TERM_EN
        mul_last = last_cnt || (mplr_q[WIDTH-1:1] == '0);
`else
        mul_last = last_cnt;
`endif
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        rem      = acc_q[2*WIDTH-1:WIDTH];
        quo      = acc_q[WIDTH-1:0];
        hi_o     = is_div_q ? (neg_hi_q ? -rem : rem) : prod_fix[2*WIDTH-1:WIDTH];
        lo_o     = is_div_q ? (neg_lo_q ? -quo : quo) : prod_fix[WIDTH-1:0];
        busy_o   = (state_q != ST_IDLE);
        done_o   = (state_q == ST_DONE);
        dz_o     = dz_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cnt_q    <= '0;
                        is_div_q <= is_div_i;
                        dz_q     <= 1'b0;
                        neg_lo_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        neg_hi_q <= signed_i && a_i[WIDTH-1];
                        if (is_div_i && (b_i == '0)) begin
                            acc_q    <= {a_i, {WIDTH{1'b1}}};
                            neg_lo_q <= 1'b0;
                            neg_hi_q <= 1'b0;
                            dz_q     <= 1'b1;
                            state_q  <= ST_DONE;
                        end else if (is_div_i) begin
                            acc_q   <= {{WIDTH{1'b0}}, mag_a};
                            mcand_q <= {{WIDTH{1'b0}}, mag_b};
                            state_q <= ST_DIV;
                        end else begin
                            acc_q   <= '0;
                            mcand_q <= {{WIDTH{1'b0}}, mag_a};
                            mplr_q  <= mag_b;
                            state_q <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q   <= acc_q + (mplr_q[0] ? mcand_q : '0);
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (mul_last) state_q <= ST_DONE;
                end
                ST_DIV: begin
                    if (!r_diff[WIDTH]) begin
                        acc_q <= {r_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_q <= {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_cnt) state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU: single-cycle ops with 1-cycle registered result, iterative mul/div with HI/LO;
// in_ready low (busy) while the engine runs. ALU_MUL_EARLY_TERM_EN enables early MUL exit.
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    logic             fire;
    logic             eng_start;
    logic             eng_signed;
    logic             eng_is_div;
    logic             eng_busy;
    logic             eng_done;
    logic             eng_dz;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;
    logic [WIDTH-1:0] alu_res;
    logic [SHAMT_W-1:0] shamt;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             res_valid_q, res_valid_d;
    logic             dz_q, dz_d;
    logic             zero_q;

    assign in_ready    = ~eng_busy;
    assign busy        = eng_busy;
    assign fire        = in_valid & in_ready;
    assign eng_start   = fire && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU);
    assign eng_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign eng_is_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign shamt       = a[SHAMT_W-1:0];

    assign result      = result_q;
    assign res_valid   = res_valid_q;
    assign zero        = zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dz_q;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (eng_start),
        .signed_i (eng_signed),
        .is_div_i (eng_is_div),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (eng_busy),
        .done_o   (eng_done),
        .hi_o     (eng_hi),
        .lo_o     (eng_lo),
        .dz_o     (eng_dz)
    );

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADDU: alu_res = a + b;
            OP_SUBU: alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_AND:  alu_res = a & b;
            OP_NOR:  alu_res = ~(a | b);
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $signed(b) >>> shamt;
            OP_LUI:  alu_res = b << 16;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        result_d    = result_q;
        res_valid_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dz_d        = dz_q;
        if (eng_done) begin
            hi_d        = eng_hi;
            lo_d        = eng_lo;
            result_d    = eng_lo;
            res_valid_d = 1'b1;
            if (eng_dz) dz_d = 1'b1;
        end else if (fire) begin
            res_valid_d = 1'b1;
            case (op)
                OP_MULT, OP_MULTU: res_valid_d = 1'b0;
                OP_DIV, OP_DIVU: begin
                    res_valid_d = 1'b0;
                    dz_d        = 1'b0;
                end
                OP_MFHI: result_d = hi_q;
                OP_MFLO: result_d = lo_q;
                OP_MTHI: begin
                    hi_d     = a;
                    result_d = a;
                end
                OP_MTLO: begin
                    lo_d     = a;
                    result_d = a;
                end
                default: result_d = alu_res;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            res_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            dz_q        <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= (result_d == '0);
            res_valid_q <= res_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dz_q        <= dz_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
module tb_alu_muldiv_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   op = 5'h00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         res_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at negedge, hold until accepted, push the hand-computed result when it fires.
    task automatic send(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input bit has_res);
        int n = 0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: op %h never accepted", o);
        end else if (has_res) begin
            exp_q.push_back(er);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_res_valid: got result %h expected no pulse", result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e);
                    chk("zero", {31'b0, zero}, {31'b0, (e == '0)});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_dz", {31'b0, div_by_zero}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

        send(OP_ADDU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
        chk("addu_latency", {31'b0, res_valid}, 32'h1);
        send(OP_SUBU, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b1);
        send(OP_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1);
        send(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
        send(OP_SRA,  32'h4, 32'h8000_0000, 32'hF800_0000, 1'b1);
        send(OP_SRL,  32'h4, 32'h8000_0000, 32'h0800_0000, 1'b1);
        send(OP_SLL,  32'h24, 32'h1, 32'h10, 1'b1);
        send(OP_AND,  32'hF0F0, 32'hFF00, 32'hF000, 1'b1);
        send(OP_NOR,  32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
        send(OP_OR,   32'h00F0, 32'h0F00, 32'h0FF0, 1'b1);
        send(OP_XOR,  32'hFF00_FF00, 32'hFFFF_0000, 32'h00FF_FF00, 1'b1);
        send(OP_LUI,  32'h0, 32'hABCD_1234, 32'h1234_0000, 1'b1);
        send(5'h1F,   32'h5, 32'h6, 32'h0, 1'b1);
        send(OP_MTHI, 32'hAAAA, 32'h0, 32'hAAAA, 1'b1);
        send(OP_MTLO, 32'h5555, 32'h0, 32'h5555, 1'b1);
        send(OP_MFHI, 32'h0, 32'h0, 32'hAAAA, 1'b1);
        send(OP_MFLO, 32'h0, 32'h0, 32'h5555, 1'b1);

        send(OP_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 1'b1);
        wait_idle(cyc);
`ifdef ALU_MUL_EARLY_TERM_EN
        chk("mult_busy_cycles", cyc, 32'd4);
`else
        chk("mult_busy_cycles", cyc, 32'd33);
`endif
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        send(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 1'b1);
        send(OP_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1);
        send(OP_MFHI, 32'h0, 32'h0, 32'h1, 1'b1);

        send(OP_DIVU, 32'h7, 32'h0, 32'hFFFF_FFFF, 1'b1);
        wait_idle(cyc);
        chk("divz_busy_cycles", cyc, 32'd1);
        chk("divz_hi", hi, 32'h7);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_flag", {31'b0, div_by_zero}, 32'h1);

        send(OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1'b1);
        chk("dz_cleared", {31'b0, div_by_zero}, 32'h0);
        wait_idle(cyc);
        chk("div_busy_cycles", cyc, 32'd33);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        wait_idle(cyc);
        chk("divmin_hi", hi, 32'h0);
        chk("divmin_lo", lo, 32'h8000_0000);
        chk("divmin_dz", {31'b0, div_by_zero}, 32'h0);

        send(OP_DIVU, 32'd100, 32'd3, 32'd33, 1'b0);
        repeat (5) @(negedge clk);
        chk("mid_div_busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'h1);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        send(OP_ADDU, 32'h2, 32'h3, 32'h5, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
